// File: rtl/fetch_req_ctrl_if.sv
// Fetch-side handshake bundle: the ICache request/response pair and the
// instruction handoff to the IF/ID stage. The master modport is the fetch
// request controller. The slave modport is the environment, which is the
// ICache together with decode.
interface fetch_req_ctrl_if #(
  parameter int WORD = 32
);
  // ICache request / response
  logic            ic_req_valid;
  logic [WORD-1:0] ic_req_addr;
  logic            ic_req_ready;
  logic            ic_resp_valid;
  logic [WORD-1:0] ic_resp_inst;

  // IF/ID handoff
  logic            if_valid;
  logic [WORD-1:0] if_pc;
  logic [WORD-1:0] if_inst;
  logic            if_ready;

  modport master (
    output ic_req_valid, ic_req_addr,
    input  ic_req_ready, ic_resp_valid, ic_resp_inst,
    output if_valid, if_pc, if_inst,
    input  if_ready
  );

  modport slave (
    input  ic_req_valid, ic_req_addr,
    output ic_req_ready, ic_resp_valid, ic_resp_inst,
    input  if_valid, if_pc, if_inst,
    output if_ready
  );
endinterface

// File: rtl/fetch_req_ctrl.sv
// Instruction-fetch request controller. It keeps exactly one ICache request
// outstanding at a time. It decides whether the external request buffer (the
// next-fetch PC register) is loaded with PC+PC_STEP or with a backend redirect
// target. It presents each fetched instruction to decode.
// A redirect always wins over sequential advance. A response that belongs to a
// request made stale by a redirect is swallowed in DROP and never presented.
module fetch_req_ctrl #(
  parameter int WORD    = 32,
  parameter int PC_STEP = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect_valid_i,
  input  logic [WORD-1:0]   redirect_pc_i,
  output logic              rb_we_o,
  output logic [WORD-1:0]   rb_din_o,
  input  logic [WORD-1:0]   rb_dout_i,
  fetch_req_ctrl_if.master  fetch
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_DROP
  } state_t;

  state_t          state_q, state_d;
  logic [WORD-1:0] inflight_pc_q, inflight_pc_d;
  logic [WORD-1:0] inst_q, inst_d;

  // Next-state, buffer-write and handshake decode; all outputs are combinational.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one
    // unassigned, which would otherwise infer a latch.
    state_d             = state_q;
    inflight_pc_d       = inflight_pc_q;
    inst_d              = inst_q;
    rb_we_o             = 1'b0;
    rb_din_o            = '0;
    fetch.ic_req_valid  = 1'b0;
    fetch.ic_req_addr   = '0;
    fetch.if_valid      = 1'b0;
    fetch.if_pc         = '0;
    fetch.if_inst       = '0;

    case (state_q)
      // One quiet cycle after reset while the buffer settles to its reset PC.
      // A redirect or a late response seen here is ignored.
      S_IDLE: state_d = S_REQ;

      S_REQ: begin
        fetch.ic_req_valid = 1'b1;
        fetch.ic_req_addr  = rb_dout_i;
        if (redirect_valid_i) begin
          rb_we_o  = 1'b1;
          rb_din_o = redirect_pc_i;
          // A request accepted in the same cycle fetches the wrong PC, so its
          // response still has to be drained.
          if (fetch.ic_req_ready) state_d = S_DROP;
        end else if (fetch.ic_req_ready) begin
          inflight_pc_d = rb_dout_i;
          rb_we_o       = 1'b1;
          rb_din_o      = rb_dout_i + WORD'(PC_STEP);
          state_d       = S_WAIT;
        end
      end

      S_WAIT: begin
        if (redirect_valid_i) begin
          rb_we_o  = 1'b1;
          rb_din_o = redirect_pc_i;
          // If the response arrives with the redirect, nothing is left in
          // flight and the controller can issue again at once.
          state_d  = fetch.ic_resp_valid ? S_REQ : S_DROP;
        end else if (fetch.ic_resp_valid) begin
          inst_d  = fetch.ic_resp_inst;
          state_d = S_HOLD;
        end
      end

      S_DROP: begin
        if (redirect_valid_i) begin
          rb_we_o  = 1'b1;
          rb_din_o = redirect_pc_i;
        end
        if (fetch.ic_resp_valid) state_d = S_REQ;
      end

      S_HOLD: begin
        fetch.if_valid = !redirect_valid_i;
        fetch.if_pc    = inflight_pc_q;
        fetch.if_inst  = inst_q;
        if (redirect_valid_i) begin
          rb_we_o  = 1'b1;
          rb_din_o = redirect_pc_i;
          state_d  = S_REQ;
        end else if (fetch.if_ready) begin
          state_d = S_REQ;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State, in-flight PC and captured instruction registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      state_q       <= S_IDLE;
      inflight_pc_q <= '0;
      inst_q        <= '0;
    end else begin
      state_q       <= state_d;
      inflight_pc_q <= inflight_pc_d;
      inst_q        <= inst_d;
    end
  end

endmodule

// File: tb/tb_fetch_req_ctrl.sv
// Self-checking bench for fetch_req_ctrl. A table of per-cycle input/expected
// output records walks the redirect, drop, hold, wrap and reset corners. Then
// a free-running fetch stream with a 1-cycle ICache is scored through a queue.
module tb_fetch_req_ctrl;
  localparam int          WORD   = 32;
  localparam logic [31:0] PC_RST = 32'h1C00_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        rb_we;
  logic [31:0] rb_din;
  logic [31:0] rb_q;

  always #5 clk = ~clk;

  fetch_req_ctrl_if #(.WORD(WORD)) fif ();

  fetch_req_ctrl #(.WORD(WORD), .PC_STEP(4)) dut (
    .clk              (clk),
    .rst              (rst),
    .redirect_valid_i (redirect_valid),
    .redirect_pc_i    (redirect_pc),
    .rb_we_o          (rb_we),
    .rb_din_o         (rb_din),
    .rb_dout_i        (rb_q),
    .fetch            (fif)
  );

  // Request buffer: the next-fetch PC register, which resets itself to PC_RST.
  always_ff @(posedge clk) begin
    if (rst)        rb_q <= PC_RST;
    else if (rb_we) rb_q <= rb_din;
  end

  typedef struct packed {
    logic        rst;
    logic        rv;
    logic [31:0] rpc;
    logic        rdy;
    logic        rsp;
    logic [31:0] rinst;
    logic        ifr;
  } in_t;

  typedef struct packed {
    logic        we;
    logic [31:0] din;
    logic        qv;
    logic [31:0] qa;
    logic        iv;
    logic [31:0] ipc;
    logic [31:0] iinst;
  } out_t;

  typedef struct {
    in_t  in;
    out_t exp;
  } vec_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } sb_t;

  vec_t tbl[$];
  out_t exp_q[$];
  sb_t  sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic in_t vi(logic r, logic rv, logic [31:0] rpc, logic rdy,
                             logic rsp, logic [31:0] ri, logic ifr);
    return {r, rv, rpc, rdy, rsp, ri, ifr};
  endfunction

  function automatic out_t vo(logic we, logic [31:0] din, logic qv, logic [31:0] qa,
                              logic iv, logic [31:0] ipc, logic [31:0] ii);
    return {we, din, qv, qa, iv, ipc, ii};
  endfunction

  function automatic out_t sample_out();
    return {rb_we, rb_din, fif.ic_req_valid, fif.ic_req_addr,
            fif.if_valid, fif.if_pc, fif.if_inst};
  endfunction

  function automatic logic [31:0] inst_of(logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  task automatic add(input in_t i, input out_t o);
    tbl.push_back('{i, o});
  endtask

  task automatic drive(input in_t i);
    rst               = i.rst;
    redirect_valid    = i.rv;
    redirect_pc       = i.rpc;
    fif.ic_req_ready  = i.rdy;
    fif.ic_resp_valid = i.rsp;
    fif.ic_resp_inst  = i.rinst;
    fif.if_ready      = i.ifr;
  endtask

  initial begin
    out_t        e;
    out_t        oz;
    in_t         iz;
    logic        resp_pend;
    logic [31:0] resp_inst;
    logic [31:0] exp_pc;
    int          n_pop;
    int          n_acc;
    int          last_acc;
    sb_t         s;

    oz = '0;
    iz = '0;
    drive(vi(1, 0, 0, 0, 0, 0, 0));

    // Reset: every output low, buffer at PC_RST.
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      @(negedge clk);
      check("reset_outputs", 160'(sample_out()), 160'(oz));
      check("reset_rb", 160'(rb_q), 160'(PC_RST));
    end

    //  in: rst rv rpc rdy rsp rinst ifr      exp: we din qv qa iv ipc inst
    add(vi(0,1,32'hDEAD0000,1,1,32'hBAD00000,0), oz);                                 // IDLE ignores all
    for (int k = 0; k < 5; k++)
      add(iz, vo(0,0,1,32'h1C000000,0,0,0));                                          // REQ stalled
    add(vi(0,0,0,1,0,0,0),                   vo(1,32'h1C000004,1,32'h1C000000,0,0,0)); // accept
    add(vi(0,1,32'h1C000100,0,0,0,0),        vo(1,32'h1C000100,0,0,0,0,0));            // WAIT redirect
    add(iz, oz);                                                                      // DROP
    add(vi(0,0,0,0,1,32'hBAD00001,1),        oz);                                      // stale resp
    add(vi(0,0,0,1,0,0,0),                   vo(1,32'h1C000104,1,32'h1C000100,0,0,0));
    add(iz, oz);                                                                      // WAIT idle
    add(vi(0,0,0,0,1,32'h00112233,0),        oz);
    add(iz,                                  vo(0,0,0,0,1,32'h1C000100,32'h00112233)); // HOLD stall
    add(iz,                                  vo(0,0,0,0,1,32'h1C000100,32'h00112233));
    add(vi(0,1,32'h1C000200,0,0,0,1),        vo(1,32'h1C000200,0,0,0,32'h1C000100,32'h00112233)); // squash
    add(vi(0,0,0,1,0,0,0),                   vo(1,32'h1C000204,1,32'h1C000200,0,0,0));
    add(vi(0,0,0,0,1,32'hCAFEF00D,0),        oz);
    add(vi(0,0,0,0,0,0,1),                   vo(0,0,0,0,1,32'h1C000200,32'hCAFEF00D));
    add(vi(0,1,32'h1C000010,0,0,0,0),        vo(1,32'h1C000010,1,32'h1C000204,0,0,0)); // REQ redirect, no accept
    add(vi(0,1,32'h1C000300,1,0,0,0),        vo(1,32'h1C000300,1,32'h1C000010,0,0,0)); // redirect + accept
    add(vi(0,1,32'h1C000400,0,0,0,0),        vo(1,32'h1C000400,0,0,0,0,0));            // DROP redirect
    add(vi(0,0,0,0,1,32'hBAD00002,1),        oz);
    add(iz,                                  vo(0,0,1,32'h1C000400,0,0,0));
    add(vi(0,0,0,1,0,0,0),                   vo(1,32'h1C000404,1,32'h1C000400,0,0,0));
    add(vi(0,1,32'h1C000500,0,1,32'hBAD00003,1), vo(1,32'h1C000500,0,0,0,0,0));        // WAIT redirect + resp
    add(iz,                                  vo(0,0,1,32'h1C000500,0,0,0));
    add(vi(0,1,32'hFFFFFFFC,0,0,0,0),        vo(1,32'hFFFFFFFC,1,32'h1C000500,0,0,0));
    add(vi(0,0,0,1,0,0,0),                   vo(1,32'h00000000,1,32'hFFFFFFFC,0,0,0)); // wrap
    add(vi(0,0,0,0,1,32'h00000013,0),        oz);
    add(vi(0,0,0,0,0,0,1),                   vo(0,0,0,0,1,32'hFFFFFFFC,32'h00000013));
    add(iz,                                  vo(0,0,1,32'h00000000,0,0,0));
    add(vi(0,0,0,1,0,0,0),                   vo(1,32'h00000004,1,32'h00000000,0,0,0));
    add(vi(1,0,0,0,0,0,0),                   oz);                                      // rst in WAIT
    add(vi(0,0,0,0,1,32'hBAD00004,0),        oz);                                      // IDLE late resp
    add(vi(0,0,0,0,1,32'hBAD00005,0),        vo(0,0,1,32'h1C000000,0,0,0));            // REQ ignores resp
    add(vi(0,0,0,1,0,0,0),                   vo(1,32'h1C000004,1,32'h1C000000,0,0,0));
    add(vi(0,0,0,0,1,32'h00000044,0),        oz);
    add(vi(0,0,0,0,0,0,1),                   vo(0,0,0,0,1,32'h1C000000,32'h00000044));

    foreach (tbl[k]) begin
      @(posedge clk); #1;
      drive(tbl[k].in);
      exp_q.push_back(tbl[k].exp);
      @(negedge clk);
      e = exp_q.pop_front();
      check($sformatf("vec%0d", k), 160'(sample_out()), 160'(e));
    end

    // Free-running stream: reset, ready everywhere, 1-cycle ICache.
    @(posedge clk); #1;
    drive(vi(1, 0, 0, 0, 0, 0, 0));
    resp_pend = 1'b0;
    resp_inst = '0;
    exp_pc    = PC_RST;
    n_pop     = 0;
    n_acc     = 0;
    last_acc  = 0;
    for (int cyc = 0; cyc < 60 && n_pop < 4; cyc++) begin
      @(posedge clk); #1;
      drive(vi(0, 0, 0, 1, resp_pend, resp_inst, 1));
      resp_pend = 1'b0;
      @(negedge clk);
      if (fif.ic_req_valid && fif.ic_req_ready) begin
        check("seq_addr", 160'(fif.ic_req_addr), 160'(exp_pc));
        check("seq_rb_din", 160'(rb_din), 160'(exp_pc + 32'd4));
        if (n_acc > 0) check("seq_spacing", 160'(cyc - last_acc), 160'(3));
        sb_q.push_back('{exp_pc, inst_of(exp_pc)});
        resp_pend = 1'b1;
        resp_inst = inst_of(fif.ic_req_addr);
        exp_pc    = exp_pc + 32'd4;
        last_acc  = cyc;
        n_acc++;
      end
      if (fif.if_valid && fif.if_ready) begin
        if (sb_q.size() == 0) begin
          check("seq_unexpected_if_valid", 160'(1), 160'(0));
        end else begin
          s = sb_q.pop_front();
          check("seq_if_pc", 160'(fif.if_pc), 160'(s.pc));
          check("seq_if_inst", 160'(fif.if_inst), 160'(s.inst));
          check("seq_latency", 160'(cyc - last_acc), 160'(2));
        end
        n_pop++;
      end
    end
    check("seq_delivered", 160'(n_pop), 160'(4));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_req_ctrl.md
Name: fetch_req_ctrl

Overview:
- Sequences the instruction-fetch request buffer, a 32-bit PC register with write-enable that resets to PC_RST.
- Decides each cycle whether the buffer is loaded with PC+4 or a redirect target.
- Drives the ICache request/response handshake and presents one fetched instruction per transaction to the IF/ID stage.
- Sits between the backend redirect logic (branch/exception), the ICache, and decode.

Parameters:
WORD, 32, address/instruction width
PC_STEP, 4, sequential PC increment in bytes

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
redirect_valid  in  1  backend redirect (branch mispredict/exception/ertn)
redirect_pc  in  WORD  redirect target
rb_we  out  1  request-buffer write enable
rb_din  out  WORD  request-buffer write data
rb_dout  in  WORD  request-buffer current value (next fetch PC)
ic_req_valid  out  1  fetch request to ICache
ic_req_addr  out  WORD  fetch address
ic_req_ready  in  1  ICache accepts request this cycle
ic_resp_valid  in  1  ICache returns instruction
ic_resp_inst  in  WORD  returned instruction
if_valid  out  1  instruction valid to decode
if_pc  out  WORD  PC of presented instruction
if_inst  out  WORD  presented instruction
if_ready  in  1  decode accepts

Behaviour:
- Registered state: FSM state, inflight_pc (WORD), inst_q (WORD). All outputs are combinational from state and inputs.
- States: IDLE, REQ, WAIT, HOLD, DROP.
- Reset: state=IDLE, inflight_pc=0, inst_q=0. In IDLE every output is 0 (rb_we=0, ic_req_valid=0, if_valid=0, ic_req_addr=0, if_pc=0, if_inst=0). The buffer self-resets to PC_RST.
- IDLE -> REQ unconditionally on the next cycle. An IDLE-cycle redirect is ignored.
- REQ: ic_req_valid=1, ic_req_addr=rb_dout.
  - redirect_valid: rb_we=1, rb_din=redirect_pc. If ic_req_ready in the same cycle, go to DROP (the accepted request is stale); else stay in REQ.
  - else ic_req_ready: inflight_pc<=rb_dout, rb_we=1, rb_din=rb_dout+PC_STEP (mod 2^WORD, wraps 0xFFFFFFFC->0x00000000), go to WAIT.
  - else: stay, rb_we=0.
- WAIT: ic_req_valid=0.
  - redirect_valid & ic_resp_valid: response discarded, rb_we=1, rb_din=redirect_pc, go to REQ.
  - redirect_valid only: rb_we=1, rb_din=redirect_pc, go to DROP.
  - ic_resp_valid only: inst_q<=ic_resp_inst, go to HOLD.
- DROP: waits for the stale response.
  - ic_resp_valid: go to REQ; data discarded, never presented.
  - redirect_valid (any cycle): rb_we=1, rb_din=redirect_pc, stay in/exit per ic_resp_valid. The latest redirect wins.
- HOLD: if_valid = !redirect_valid, if_pc=inflight_pc, if_inst=inst_q.
  - redirect_valid: rb_we=1, rb_din=redirect_pc, go to REQ; the instruction is squashed.
  - else if_ready: go to REQ.
  - else hold, outputs stable.
- Exactly one outstanding ICache request at any time. ic_req_valid is never asserted in WAIT/HOLD/DROP.
- rb_we=0 and rb_din=0 whenever no write is specified above.
- Redirect always has priority over sequential advance.
- Minimum 3 cycles per instruction (REQ->WAIT->HOLD). Latency from request accept to if_valid = ICache latency + 1.
- rst asserted in any state returns to IDLE next edge. An in-flight response arriving after reset is ignored: IDLE/REQ ignore ic_resp_valid.
- redirect_pc is passed unmodified; alignment faults are handled elsewhere.

Test Plan:
- Reset release, ic_req_ready=1, 1-cycle ICache, if_ready=1 -> requests at 0x1C000000, 0x1C000004, 0x1C000008, one every 3 cycles; if_pc matches each; rb_din=addr+4 on each accept.
- ic_req_ready held low 5 cycles in REQ -> ic_req_valid=1, ic_req_addr=0x1C000000 stable, rb_we=0 throughout.
- Redirect to 0x1C000100 one cycle after accept of 0x1C000000, response 3 cycles later -> DROP; response not presented (if_valid=0); next request addr=0x1C000100.
- Redirect to 0x1C000200 in HOLD with if_ready=1 -> if_valid=0 that cycle, no handoff; next request 0x1C000200.
- Redirect and ic_req_ready same cycle in REQ (addr 0x1C000010, target 0x1C000300), then a second redirect to 0x1C000400 during DROP -> stale response discarded; next request 0x1C000400.
- rst pulsed in WAIT, ICache response arrives during IDLE/REQ -> response ignored; first request after reset 0x1C000000; sequential wrap from 0xFFFFFFFC writes rb_din=0x00000000.
